// File: rtl/dom_gf_mul_pipe_pkg.sv
// Shared types and helpers for the domain-oriented masked GF(2^W) multiplier.
package dom_gf_mul_pipe_pkg;

  typedef logic [0:0] bv1;
  typedef logic [1:0] bv2;
  typedef logic [3:0] bv4;

  // Widest supported field; every field element fits in a bv4.
  localparam int MAX_W = 4;

  // Number of unordered share pairs, i.e. fresh random words per multiply.
  function automatic int num_quad(input int n);
    return (n * (n - 1)) / 2;
  endfunction

  // Flat index of the unordered pair {i,j}; symmetric in i and j.
  // A pair of a share with itself does not exist and yields -1.
  function automatic int pair_index(input int i, input int j, input int n);
    int lo;
    int hi;
    if (i == j) return -1;
    lo = (i < j) ? i : j;
    hi = (i < j) ? j : i;
    return lo * n - (lo * (lo + 1)) / 2 + hi - lo - 1;
  endfunction

  // Polynomial-basis GF(2^w) multiply: shift-and-add with interleaved
  // reduction. Both x^4+x+1 and x^2+x+1 fold the top bit back as x+1.
  function automatic bv4 gf_mul(input bv4 a, input bv4 b, input int w);
    bv4   acc;
    bv4   sh;
    bv4   mask;
    bv4   red;
    logic carry;
    mask = bv4'((1 << w) - 1);
    red  = (w == 1) ? 4'b0000 : 4'b0011;
    acc  = '0;
    sh   = a & mask;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < w) begin
        if (((b >> i) & 4'b0001) != 4'b0000) acc = acc ^ sh;
        carry = |(sh & bv4'(1 << (w - 1)));
        sh    = (sh << 1) & mask;
        if (carry) sh = sh ^ red;
      end
    end
    return acc & mask;
  endfunction

endpackage

// File: rtl/dom_cross_term.sv
// One masked cross-domain product x_a*y_b ^ r, registered on enable.
module dom_cross_term
  import dom_gf_mul_pipe_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] x_a,
  input  logic [W-1:0] y_b,
  input  logic [W-1:0] r,
  output logic [W-1:0] q
);

  bv4   mix;
  logic unused_mix;

  assign mix        = gf_mul(bv4'(x_a), bv4'(y_b), W) ^ bv4'(r);
  assign unused_mix = ^mix;

  // Capture the remasked term; this register keeps glitches of the
  // unmasked product from reaching the compression XOR.
  always_ff @(posedge clk) begin
    if (rst)     q <= '0;
    else if (en) q <= mix[W-1:0];
  end

endmodule

// File: rtl/dom_gf_mul_pipe.sv
// Two-stage DOM masked multiplier over GF(2^W) with valid/ready flow control.
module dom_gf_mul_pipe
  import dom_gf_mul_pipe_pkg::*;
#(
  parameter  int N_SHARES = 2,
  parameter  int W        = 4,
  localparam int NQ       = num_quad(N_SHARES)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [N_SHARES*W-1:0] x_i,
  input  logic [N_SHARES*W-1:0] y_i,
  input  logic [NQ*W-1:0]       r_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [N_SHARES*W-1:0] z_o
);

  if (!(W == 1 || W == 2 || W == 4)) begin : g_bad_w
    $error("dom_gf_mul_pipe: W must be 1, 2 or 4");
  end
  if (N_SHARES < 2 || N_SHARES > 5) begin : g_bad_n
    $error("dom_gf_mul_pipe: N_SHARES must be in 2..5");
  end

  logic vld_p1;
  logic vld_p2;
  logic s1_adv;
  logic s2_adv;
  logic accept;

  assign s2_adv      = !vld_p2 || out_ready_i;
  assign s1_adv      = vld_p1 && s2_adv;
  assign in_ready_o  = !vld_p1 || s2_adv;
  assign accept      = in_valid_i && in_ready_o;
  assign out_valid_o = vld_p2;

  // Stage occupancy: a stage refills from upstream whenever it may move.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (in_ready_o) vld_p1 <= in_valid_i;
      if (s2_adv)     vld_p2 <= vld_p1;
    end
  end

  for (genvar a = 0; a < N_SHARES; a++) begin : g_dom
    bv4           inner_full;
    logic         unused_inner;
    logic [W-1:0] inner_p1;
    logic [W-1:0] part [N_SHARES+1];
    logic [W-1:0] z_p2;

    // ---- stage 1: domain-local product and remasked cross terms ----
    assign inner_full   = gf_mul(bv4'(x_i[a*W +: W]), bv4'(y_i[a*W +: W]), W);
    assign unused_inner = ^inner_full;

    // Inner product needs no fresh mask; it never leaves its own domain.
    always_ff @(posedge clk_i) begin
      if (rst_i)       inner_p1 <= '0;
      else if (accept) inner_p1 <= inner_full[W-1:0];
    end

    assign part[0] = inner_p1;

    for (genvar b = 0; b < N_SHARES; b++) begin : g_peer
      if (a != b) begin : g_x
        localparam int PI = pair_index(a, b, N_SHARES);
        logic [W-1:0] cross_p1;

        dom_cross_term #(.W(W)) u_cross (
          .clk (clk_i),
          .rst (rst_i),
          .en  (accept),
          .x_a (x_i[a*W +: W]),
          .y_b (y_i[b*W +: W]),
          .r   (r_i[PI*W +: W]),
          .q   (cross_p1)
        );

        assign part[b+1] = part[b] ^ cross_p1;
      end else begin : g_self
        assign part[b+1] = part[b];
      end
    end

    // ---- stage 2: compress registered terms into the output share ----
    // Output share only moves when stage 1 hands over a beat.
    always_ff @(posedge clk_i) begin
      if (rst_i)       z_p2 <= '0;
      else if (s1_adv) z_p2 <= part[N_SHARES];
    end

    assign z_o[a*W +: W] = z_p2;
  end

endmodule

// File: tb/tb_dom_gf_mul_pipe.sv
// Scoreboard bench for dom_gf_mul_pipe in three share/width configurations.
module tb_dom_gf_mul_pipe;
  import dom_gf_mul_pipe_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // A: 3 shares, GF(2^4)
  logic        a_rst, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [11:0] a_x, a_y, a_r, a_z;
  // B: 5 shares, GF(2)
  logic        bc_rst;
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [4:0]  b_x, b_y, b_z;
  logic [9:0]  b_r;
  // C: 3 shares, GF(2^2)
  logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready;
  logic [5:0]  c_x, c_y, c_r, c_z;

  dom_gf_mul_pipe #(.N_SHARES(3), .W(4)) u_a (
    .clk_i(clk), .rst_i(a_rst), .in_valid_i(a_in_valid), .in_ready_o(a_in_ready),
    .x_i(a_x), .y_i(a_y), .r_i(a_r), .out_valid_o(a_out_valid),
    .out_ready_i(a_out_ready), .z_o(a_z));

  dom_gf_mul_pipe #(.N_SHARES(5), .W(1)) u_b (
    .clk_i(clk), .rst_i(bc_rst), .in_valid_i(b_in_valid), .in_ready_o(b_in_ready),
    .x_i(b_x), .y_i(b_y), .r_i(b_r), .out_valid_o(b_out_valid),
    .out_ready_i(b_out_ready), .z_o(b_z));

  dom_gf_mul_pipe #(.N_SHARES(3), .W(2)) u_c (
    .clk_i(clk), .rst_i(bc_rst), .in_valid_i(c_in_valid), .in_ready_o(c_in_ready),
    .x_i(c_x), .y_i(c_y), .r_i(c_r), .out_valid_o(c_out_valid),
    .out_ready_i(c_out_ready), .z_o(c_z));

  typedef struct {
    logic        full;
    logic [11:0] z;
    logic [3:0]  zx;
  } exp_a_t;

  exp_a_t     qa[$];
  logic       qb[$];
  logic [1:0] qc[$];
  exp_a_t     ea;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got timeout or unexpected beat, expected in-order completion", name);
  endtask

  // Reference multiply: full carry-less product, then reduce high terms.
  function automatic logic [3:0] ref_mul(input logic [3:0] a, input logic [3:0] b, input int w);
    logic [7:0] p;
    p = '0;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ (8'(a) << i);
    end
    if (w == 4) begin
      for (int k = 6; k >= 4; k--) begin
        if (p[k]) p = p ^ (8'h13 << (k - 4));
      end
    end else if (w == 2) begin
      if (p[2]) p = p ^ 8'h07;
    end
    return p[3:0];
  endfunction

  function automatic logic [3:0] xor3x4(input logic [11:0] v);
    return v[3:0] ^ v[7:4] ^ v[11:8];
  endfunction

  function automatic logic [1:0] xor3x2(input logic [5:0] v);
    return v[1:0] ^ v[3:2] ^ v[5:4];
  endfunction

  // Monitors: pop one expectation per completed output handshake.
  always @(negedge clk) begin
    if (!a_rst && a_out_valid && a_out_ready) begin
      if (qa.size() == 0) fail_now("a_unexpected");
      else begin
        ea = qa.pop_front();
        if (ea.full) check("a_shares", 32'(a_z), 32'(ea.z));
        check("a_xor", 32'(xor3x4(a_z)), 32'(ea.zx));
      end
    end
  end

  always @(negedge clk) begin
    if (!bc_rst && b_out_valid && b_out_ready) begin
      if (qb.size() == 0) fail_now("b_unexpected");
      else check("b_xor", 32'(^b_z), 32'(qb.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (!bc_rst && c_out_valid && c_out_ready) begin
      if (qc.size() == 0) fail_now("c_unexpected");
      else check("c_xor", 32'(xor3x2(c_z)), 32'(qc.pop_front()));
    end
  end

  task automatic send_a(input logic [11:0] x, input logic [11:0] y, input logic [11:0] r,
                        input logic full, input logic [11:0] zf, input logic push);
    logic   ok;
    int     guard;
    exp_a_t e;
    ok = 1'b0;
    guard = 0;
    e.full = full;
    e.z    = zf;
    e.zx   = ref_mul(xor3x4(x), xor3x4(y), 4);
    a_in_valid = 1'b1;
    a_x = x;
    a_y = y;
    a_r = r;
    while (!ok && guard < 40) begin
      @(negedge clk);
      ok = a_in_ready;
      if (ok && push) qa.push_back(e);
      @(posedge clk);
      #1;
      guard++;
    end
    a_in_valid = 1'b0;
    if (!ok) fail_now("a_accept");
  endtask

  task automatic drain(input string name);
    int guard;
    guard = 0;
    while ((qa.size() + qb.size() + qc.size()) != 0 && guard < 100) begin
      @(posedge clk);
      guard++;
    end
    #1;
    check(name, 32'(qa.size() + qb.size() + qc.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cnt [10];
    logic [4:0]  s5;
    logic [1:0]  s0, s1;
    logic [1:0]  cx_t [5];
    logic [1:0]  cy_t [5];
    logic [1:0]  cz_t [5];

    a_rst = 1'b1; bc_rst = 1'b1;
    a_in_valid = 1'b0; a_out_ready = 1'b1; a_x = '0; a_y = '0; a_r = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b1; b_x = '0; b_y = '0; b_r = '0;
    c_in_valid = 1'b0; c_out_ready = 1'b1; c_x = '0; c_y = '0; c_r = '0;
    repeat (3) @(posedge clk);
    #1;
    a_rst = 1'b0; bc_rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", 32'(a_out_valid), 32'd0);
    check("rst_in_ready", 32'(a_in_ready), 32'd1);
    check("rst_z", 32'(a_z), 32'd0);
    check("rst_b_out_valid", 32'(b_out_valid), 32'd0);
    @(posedge clk);
    #1;

    // Latency: shares {5,6,0} x {1,6,0}, r01=A -> z shares {2,B,0}
    send_a(12'h065, 12'h061, 12'h00A, 1'b1, 12'h0B2, 1'b1);
    @(negedge clk);
    check("lat_cycle1", 32'(a_out_valid), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("lat_cycle2", 32'(a_out_valid), 32'd1);
    @(posedge clk);
    #1;

    // Back-to-back directed beats, then random beats
    send_a(12'h421, 12'h111, 12'h653, 1'b1, 12'h777, 1'b1);
    send_a(12'h003, 12'h070, 12'h000, 1'b1, 12'h009, 1'b1);
    send_a(12'h800, 12'h800, 12'h000, 1'b1, 12'hC00, 1'b1);
    for (int i = 0; i < 20; i++)
      send_a(12'($urandom), 12'($urandom), 12'($urandom), 1'b0, 12'h000, 1'b1);
    // Idle with changing inputs: nothing may be accepted
    for (int i = 0; i < 4; i++) begin
      a_x = 12'($urandom); a_y = 12'($urandom); a_r = 12'($urandom);
      @(posedge clk);
      #1;
    end
    drain("drain_stream");

    // Backpressure: two accepts fill the pipe, then stall with junk inputs
    a_out_ready = 1'b0;
    send_a(12'h421, 12'h111, 12'h653, 1'b1, 12'h777, 1'b1);
    send_a(12'h065, 12'h061, 12'h00A, 1'b1, 12'h0B2, 1'b1);
    for (int i = 0; i < 5; i++) begin
      a_in_valid = 1'b1;
      a_x = 12'($urandom); a_y = 12'($urandom); a_r = 12'($urandom);
      @(negedge clk);
      check("stall_in_ready", 32'(a_in_ready), 32'd0);
      check("stall_out_valid", 32'(a_out_valid), 32'd1);
      check("stall_z_hold", 32'(a_z), 32'h777);
      @(posedge clk);
      #1;
    end
    a_in_valid = 1'b0;
    a_out_ready = 1'b1;
    send_a(12'h800, 12'h800, 12'h000, 1'b1, 12'hC00, 1'b1);
    drain("drain_stall");

    // Reset one cycle after accept, with in_valid held high through reset
    send_a(12'h421, 12'h111, 12'h653, 1'b1, 12'h777, 1'b0);
    a_rst = 1'b1;
    a_in_valid = 1'b1;
    @(posedge clk);
    #1;
    a_rst = 1'b0;
    a_in_valid = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", 32'(a_out_valid), 32'd0);
    check("midrst_z", 32'(a_z), 32'd0);
    check("midrst_in_ready", 32'(a_in_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_no_beat", 32'(a_out_valid), 32'd0);
    end
    @(posedge clk);
    #1;

    // GF(2), five shares: exhaustive x,y with random shares and masks
    for (int rep = 0; rep < 4; rep++) begin
      for (int xv = 0; xv < 2; xv++) begin
        for (int yv = 0; yv < 2; yv++) begin
          b_in_valid = 1'b1;
          s5 = 5'($urandom); s5[4] = (^s5[3:0]) ^ xv[0]; b_x = s5;
          s5 = 5'($urandom); s5[4] = (^s5[3:0]) ^ yv[0]; b_y = s5;
          b_r = 10'($urandom);
          @(negedge clk);
          check("b_in_ready", 32'(b_in_ready), 32'd1);
          if (b_in_ready) qb.push_back(xv[0] & yv[0]);
          @(posedge clk);
          #1;
        end
      end
    end
    b_in_valid = 1'b0;

    // GF(2^2), three shares: long back-to-back stream of hand-computed products
    cx_t[0] = 2'd2; cy_t[0] = 2'd2; cz_t[0] = 2'd3;
    cx_t[1] = 2'd3; cy_t[1] = 2'd3; cz_t[1] = 2'd2;
    cx_t[2] = 2'd2; cy_t[2] = 2'd3; cz_t[2] = 2'd1;
    cx_t[3] = 2'd1; cy_t[3] = 2'd3; cz_t[3] = 2'd3;
    cx_t[4] = 2'd0; cy_t[4] = 2'd2; cz_t[4] = 2'd0;
    for (int i = 0; i < 200; i++) begin
      c_in_valid = 1'b1;
      s0 = 2'($urandom); s1 = 2'($urandom);
      c_x = {cx_t[i % 5] ^ s0 ^ s1, s1, s0};
      s0 = 2'($urandom); s1 = 2'($urandom);
      c_y = {cy_t[i % 5] ^ s0 ^ s1, s1, s0};
      c_r = 6'($urandom);
      @(negedge clk);
      check("c_in_ready", 32'(c_in_ready), 32'd1);
      if (c_in_ready) qc.push_back(cz_t[i % 5]);
      @(posedge clk);
      #1;
    end
    c_in_valid = 1'b0;
    drain("drain_bc");

    // Every pair word of a five-share multiply feeds exactly two domains
    for (int p = 0; p < 10; p++) cnt[p] = 0;
    for (int a = 0; a < 5; a++)
      for (int b = 0; b < 5; b++)
        if (a != b) cnt[pair_index(a, b, 5)]++;
    for (int p = 0; p < 10; p++) check("pair_use", 32'(cnt[p]), 32'd2);
    check("pair_idx_12", 32'(pair_index(1, 2, 3)), 32'd2);
    check("pair_idx_20", 32'(pair_index(2, 0, 3)), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
